// File: rtl/yuv422_packer.sv
// yuv422_packer: pairs adjacent 4:4:4 YUV pixels into 4:2:2 words.
// Ports: in_* pixel handshake with in_sol, out_* pair handshake with out_eol, sticky sync_err.
module yuv422_packer #(
  parameter int BITS   = 9,
  parameter int LINE_W = 640
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sol,
  input  logic [BITS-1:0] in_y,
  input  logic [BITS-1:0] in_u,
  input  logic [BITS-1:0] in_v,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_y0,
  output logic [BITS-1:0] out_y1,
  output logic [BITS-1:0] out_u,
  output logic [BITS-1:0] out_v,
  output logic            out_eol,
  output logic            sync_err
);

  localparam int PAIRS = LINE_W / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [BITS-1:0] hy;
  logic [BITS-1:0] hu;
  logic [BITS-1:0] hv;
  logic [CW-1:0]   cnt;
  logic            in_xfer;
  logic            out_xfer;
  logic            load;
  logic            capture;
  logic            resync;
  logic [BITS:0]   su;
  logic [BITS:0]   sv;

  // In ODD the incoming pixel completes a pair, so the output
  // register must be free (or draining) before accepting it.
  assign in_ready = (state == EVEN) || !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign load     = in_xfer && (state == ODD) && !in_sol;
  assign resync   = in_xfer && (state == ODD) && in_sol;
  assign capture  = in_xfer && ((state == EVEN) || in_sol);

  // Sign-extended sum; dropping bit 0 is a floor shift.
  assign su = {hu[BITS-1], hu} + {in_u[BITS-1], in_u};
  assign sv = {hv[BITS-1], hv} + {in_v[BITS-1], in_v};

  always_ff @(posedge clk) begin
    if (rst) state <= EVEN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EVEN:    if (in_xfer) state_nx = ODD;
      ODD:     if (load)    state_nx = EVEN;
      default: state_nx = EVEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hy        <= '0;
      hu        <= '0;
      hv        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_y0    <= '0;
      out_y1    <= '0;
      out_u     <= '0;
      out_v     <= '0;
      out_eol   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (capture) begin
        hy <= in_y;
        hu <= in_u;
        hv <= in_v;
      end
      if (load) begin
        out_y0    <= hy;
        out_y1    <= in_y;
        out_u     <= su[BITS:1];
        out_v     <= sv[BITS:1];
        out_eol   <= (cnt == LAST);
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (in_xfer && in_sol)
        cnt <= '0;
      else if (load)
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (resync)
        sync_err <= 1'b1;
    end
  end

endmodule
